// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_pkg
//  Description : Shared definitions for the scoreboarded register file:
//                default geometry, the hardwired zero-register address and
//                the pending-write counter type.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_scoreboard_pkg;

    localparam int REGFILE_XLEN     = 32;
    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_PEND_W   = 2;

    // Architectural index of the register that may be hardwired to zero.
    localparam int REG_ZERO = 0;

    typedef logic [REGFILE_PEND_W-1:0] pend_cnt_t;

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_pending_counter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_pending_counter
//  Description : One pending-write counter. Increments on issue, decrements
//                on writeback, clears on flush; holds at both ends and
//                reports zero/saturated flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard_pending_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int PEND_W = REGFILE_PEND_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              clr_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              zero_o,
    output logic              sat_o
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    assign cnt_o  = cnt_q;
    assign zero_o = ~|cnt_q;
    assign sat_o  = &cnt_q;

    // Next count: clear dominates; inc and dec together cancel; ends never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !sat_o) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    // Count register, discarded immediately on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : regfile_scoreboard_pending_counter
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Decode-stage register file with write-to-read bypass and
//                per-register pending-write counters that produce busy,
//                issue-ready and stall indications.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int XLEN         = REGFILE_XLEN,
    parameter  int NUM_REGS     = REGFILE_NUM_REGS,
    parameter  int NUM_RD_PORTS = 2,
    parameter  int PEND_W       = REGFILE_PEND_W,
    parameter  int ZERO_REG     = 1,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]  reg_r_addr_i,
    output logic [NUM_RD_PORTS-1:0][XLEN-1:0] reg_r_data_o,
    output logic [NUM_RD_PORTS-1:0]          reg_r_busy_o,
    input  logic                             reg_w_en_i,
    input  logic [AW-1:0]                    reg_w_addr_i,
    input  logic [XLEN-1:0]                  reg_w_data_i,
    input  logic                             issue_en_i,
    input  logic [AW-1:0]                    issue_rd_i,
    output logic                             issue_ready_o,
    input  logic                             flush_i,
    output logic                             stall_o
);

    localparam bit C_HAS_ZERO = (ZERO_REG != 0);

    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [PEND_W-1:0] w_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] w_cnt_zero;
    logic [NUM_REGS-1:0] w_cnt_sat;

    logic w_wr_is_zero;
    logic w_wr_commit;
    logic w_rd_is_zero;
    logic w_issue_ok;

    assign w_wr_is_zero = C_HAS_ZERO && (reg_w_addr_i == AW'(REG_ZERO));
    assign w_wr_commit  = reg_w_en_i && !w_wr_is_zero;
    assign w_rd_is_zero = C_HAS_ZERO && (issue_rd_i == AW'(REG_ZERO));

    // A saturated destination can still issue if its writeback lands this cycle.
    assign issue_ready_o = w_rd_is_zero || !w_cnt_sat[issue_rd_i] ||
                           (reg_w_en_i && (reg_w_addr_i == issue_rd_i));
    assign w_issue_ok    = issue_en_i && issue_ready_o && !flush_i;
    assign stall_o       = (|reg_r_busy_o) || (issue_en_i && !issue_ready_o);

    // Register array; writes commit regardless of flush state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_commit) begin
            regs_q[reg_w_addr_i] <= reg_w_data_i;
        end
    end

    // One pending-write counter per architectural register.
    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
            logic w_inc;
            logic w_dec;

            assign w_inc = w_issue_ok && (issue_rd_i == AW'(r)) &&
                           !(C_HAS_ZERO && (r == REG_ZERO));
            // Stragglers arriving after a flush find a zero count and are ignored.
            assign w_dec = reg_w_en_i && (reg_w_addr_i == AW'(r)) && !w_cnt_zero[r];

            regfile_scoreboard_pending_counter #(
                .PEND_W (PEND_W)
            ) u_pending_counter (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .inc_i   (w_inc),
                .dec_i   (w_dec),
                .clr_i   (flush_i),
                .cnt_o   (w_cnt[r]),
                .zero_o  (w_cnt_zero[r]),
                .sat_o   (w_cnt_sat[r])
            );
        end
    endgenerate

    // Bypassed combinational read ports with busy derived from the counters.
    generate
        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_is_zero;
            logic          w_bypass;

            assign w_addr    = reg_r_addr_i[p];
            assign w_is_zero = C_HAS_ZERO && (w_addr == AW'(REG_ZERO));
            assign w_bypass  = reg_w_en_i && (reg_w_addr_i == w_addr);

            assign reg_r_data_o[p] = w_is_zero ? '0 :
                                     w_bypass  ? reg_w_data_i : regs_q[w_addr];

            // The last outstanding write being written back now is no longer a hazard.
            assign reg_r_busy_o[p] = !w_is_zero && !w_cnt_zero[w_addr] &&
                                     !(w_bypass && (w_cnt[w_addr] == PEND_W'(1)));
        end
    endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed self-checking bench for regfile_scoreboard with
//                default geometry (32 x 32-bit, 2 read ports, 2-bit counters,
//                hardwired zero register).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int AW = 5;

    logic                 clk;
    logic                 rst_n;
    logic [1:0][AW-1:0]   r_addr;
    logic [1:0][31:0]     r_data;
    logic [1:0]           r_busy;
    logic                 w_en;
    logic [AW-1:0]        w_addr;
    logic [31:0]          w_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ready;
    logic                 flush;
    logic                 stall;

    int n_checks;
    int n_fail;

    regfile_scoreboard dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .reg_r_addr_i  (r_addr),
        .reg_r_data_o  (r_data),
        .reg_r_busy_o  (r_busy),
        .reg_w_en_i    (w_en),
        .reg_w_addr_i  (w_addr),
        .reg_w_data_i  (w_data),
        .issue_en_i    (iss_en),
        .issue_rd_i    (iss_rd),
        .issue_ready_o (iss_ready),
        .flush_i       (flush),
        .stall_o       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        iss_en = 1'b0;
        iss_rd = '0;
        flush  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        r_addr   = '0;
        idle();

        // Held in reset
        #12;
        chk("rst_data0", r_data[0], 32'h0);
        chk("rst_busy",  {30'd0, r_busy}, 32'h0);
        chk("rst_ready", {31'd0, iss_ready}, 32'h1);
        chk("rst_stall", {31'd0, stall}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Zero register and untouched register read as zero
        r_addr[0] = 5'd0; r_addr[1] = 5'd5;
        #1;
        chk("x0_data", r_data[0], 32'h0);
        chk("x5_data", r_data[1], 32'h0);
        chk("x0_x5_busy", {30'd0, r_busy}, 32'h0);
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'hDEADBEEF;
        #1;
        chk("x0_wr_bypass", r_data[0], 32'h0);
        tick();
        idle();
        #1;
        chk("x0_after_wr", r_data[0], 32'h0);

        // Same-cycle bypass then stored value
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h12345678; r_addr[1] = 5'd3;
        #1;
        chk("x3_bypass", r_data[1], 32'h12345678);
        tick();
        idle();
        #1;
        chk("x3_stored", r_data[1], 32'h12345678);

        // Single pending write on x7
        iss_en = 1'b1; iss_rd = 5'd7;
        #1;
        chk("x7_ready", {31'd0, iss_ready}, 32'h1);
        tick();
        idle();
        r_addr[0] = 5'd7;
        #1;
        chk("x7_busy", {31'd0, r_busy[0]}, 32'h1);
        chk("x7_stall", {31'd0, stall}, 32'h1);
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h55;
        #1;
        chk("x7_wb_busy", {31'd0, r_busy[0]}, 32'h0);
        chk("x7_wb_data", r_data[0], 32'h55);
        chk("x7_wb_stall", {31'd0, stall}, 32'h0);
        tick();
        idle();
        #1;
        chk("x7_cleared", {31'd0, r_busy[0]}, 32'h0);

        // Saturate x9 with three issues, then a refused fourth
        iss_en = 1'b1; iss_rd = 5'd9;
        tick(); tick(); tick();
        chk("x9_not_ready", {31'd0, iss_ready}, 32'h0);
        chk("x9_refuse_stall", {31'd0, stall}, 32'h1);
        tick();
        idle();
        r_addr[0] = 5'd9;
        #1;
        chk("x9_busy_sat", {31'd0, r_busy[0]}, 32'h1);
        iss_rd = 5'd9;
        w_en = 1'b1; w_addr = 5'd9; w_data = 32'hA1;
        #1;
        chk("x9_ready_on_wb", {31'd0, iss_ready}, 32'h1);
        chk("x9_wb1_busy", {31'd0, r_busy[0]}, 32'h1);
        tick();
        w_data = 32'hA2;
        #1;
        chk("x9_wb2_busy", {31'd0, r_busy[0]}, 32'h1);
        tick();
        w_data = 32'hA3;
        #1;
        chk("x9_wb3_busy", {31'd0, r_busy[0]}, 32'h0);
        chk("x9_wb3_data", r_data[0], 32'hA3);
        tick();
        idle();
        #1;
        chk("x9_idle_busy", {31'd0, r_busy[0]}, 32'h0);

        // Issue and writeback of x4 in the same cycle keeps count at one
        iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        r_addr[0] = 5'd4;
        w_en = 1'b1; w_addr = 5'd4; w_data = 32'h44;
        tick();
        idle();
        #1;
        chk("x4_still_busy", {31'd0, r_busy[0]}, 32'h1);
        w_en = 1'b1; w_addr = 5'd4; w_data = 32'h45;
        tick();
        idle();
        #1;
        chk("x4_drained", {31'd0, r_busy[0]}, 32'h0);

        // Flush wins over a simultaneous issue
        iss_en = 1'b1; iss_rd = 5'd2;
        tick();
        iss_rd = 5'd6;
        tick();
        r_addr[0] = 5'd2; r_addr[1] = 5'd6;
        iss_en = 1'b0;
        #1;
        chk("pre_flush_busy", {30'd0, r_busy}, 32'h3);
        iss_en = 1'b1; iss_rd = 5'd8; flush = 1'b1;
        tick();
        idle();
        #1;
        chk("post_flush_busy", {30'd0, r_busy}, 32'h0);
        r_addr[1] = 5'd8;
        #1;
        chk("x8_not_busy", {31'd0, r_busy[1]}, 32'h0);

        // Straggler writeback after flush: data lands, counter stays at zero
        w_en = 1'b1; w_addr = 5'd2; w_data = 32'h77;
        tick();
        idle();
        #1;
        chk("x2_straggler_data", r_data[0], 32'h77);
        chk("x2_straggler_busy", {31'd0, r_busy[0]}, 32'h0);
        iss_en = 1'b1; iss_rd = 5'd2;
        tick();
        idle();
        #1;
        chk("x2_no_underflow", {31'd0, r_busy[0]}, 32'h1);

        // Asynchronous reset between edges
        r_addr[1] = 5'd3;
        #1;
        chk("x3_before_rst", r_data[1], 32'h12345678);
        rst_n = 1'b0;
        #1;
        chk("async_busy", {30'd0, r_busy}, 32'h0);
        chk("async_x3", r_data[1], 32'h0);
        chk("async_x2", r_data[0], 32'h0);
        chk("async_stall", {31'd0, stall}, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        chk("after_rst_x3", r_data[1], 32'h0);
        chk("after_rst_busy", {31'd0, r_busy[0]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_scoreboard
`default_nettype wire
